// File: rtl/biss_pos_uart_streamer_if.sv
// Signal bundle between the SCD capture side and the position streamer.
//
// Handshake: scd_valid is a one-cycle strobe with no back-pressure. The
// streamer samples scd_data/crc_ok on every clk edge where scd_valid is high;
// the producer never waits. Frames that cannot be held are counted in drop_cnt.
interface biss_pos_uart_streamer_if;
    logic        stream_en;
    logic        scd_valid;
    logic [31:0] scd_data;
    logic        crc_ok;
    logic        tx;
    logic        busy;
    logic [7:0]  drop_cnt;
    logic [15:0] pkt_cnt;
    logic [1:0]  fsm_state;

    modport master (
        output stream_en, scd_valid, scd_data, crc_ok,
        input  tx, busy, drop_cnt, pkt_cnt, fsm_state
    );

    modport slave (
        input  stream_en, scd_valid, scd_data, crc_ok,
        output tx, busy, drop_cnt, pkt_cnt, fsm_state
    );
endinterface

// File: rtl/biss_pos_uart_streamer.sv
// Serialises each accepted BiSS-C SCD word as a 9-byte framed position
// packet on an 8N1 UART line, with a one-deep newest-wins pending buffer.
module biss_pos_uart_streamer #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned CMD_CODE     = 148
) (
    input  logic                      clk,
    input  logic                      rst_n,
    biss_pos_uart_streamer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

    localparam logic [7:0] LAST_TICK = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] CMD_BYTE  = 8'(CMD_CODE);
    localparam logic [3:0] LAST_BYTE = 4'd8;

    state_t      state_q, state_d;
    logic [7:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic [23:0] act_pos_q, act_pos_d;
    logic [7:0]  act_status_q, act_status_d;
    logic [23:0] pend_pos_q, pend_pos_d;
    logic [7:0]  pend_status_q, pend_status_d;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    logic [7:0]  in_status;
    logic [7:0]  cur_byte;
    logic        tick_done;
    logic        eop;
    logic        accept;
    logic        promote;
    logic        start_direct;
    logic        tx_d;

    // Error/warning inputs are active low; the status byte reports them active high.
    assign in_status    = {5'b0, ~bus.scd_data[6], ~bus.scd_data[7], bus.crc_ok};
    assign accept       = bus.scd_valid & bus.stream_en;
    assign tick_done    = (clk_cnt_q == LAST_TICK);
    assign eop          = (state_q == STOP) && tick_done && (byte_cnt_q == LAST_BYTE);
    // Pending word becomes active either at the end of a packet or if it is
    // left over in IDLE (strobe landed on the final stop-bit cycle).
    assign promote      = bus.stream_en && pend_vld_q && ((state_q == IDLE) || eop);
    assign start_direct = (state_q == IDLE) && !pend_vld_q && accept;

    // Byte currently on the wire; the last byte is the two's complement of the running sum.
    always_comb begin
        cur_byte = 8'h00;
        case (byte_cnt_q)
            4'd0:    cur_byte = 8'h04;
            4'd1:    cur_byte = 8'h00;
            4'd2:    cur_byte = 8'h00;
            4'd3:    cur_byte = CMD_BYTE;
            4'd4:    cur_byte = act_pos_q[23:16];
            4'd5:    cur_byte = act_pos_q[15:8];
            4'd6:    cur_byte = act_pos_q[7:0];
            4'd7:    cur_byte = act_status_q;
            default: cur_byte = 8'h00 - sum_q;
        endcase
    end

    // Active/pending capture and drop accounting.
    always_comb begin
        act_pos_d     = act_pos_q;
        act_status_d  = act_status_q;
        pend_pos_d    = pend_pos_q;
        pend_status_d = pend_status_q;
        pend_vld_d    = pend_vld_q;
        drop_cnt_d    = drop_cnt_q;
        if (promote) begin
            act_pos_d    = pend_pos_q;
            act_status_d = pend_status_q;
            pend_vld_d   = 1'b0;
        end
        if (start_direct) begin
            act_pos_d    = bus.scd_data[31:8];
            act_status_d = in_status;
        end
        if (!bus.stream_en) begin
            pend_vld_d = 1'b0;
        end else if (accept && !start_direct) begin
            pend_pos_d    = bus.scd_data[31:8];
            pend_status_d = in_status;
            pend_vld_d    = 1'b1;
            // Overwriting an unconsumed word is a drop; a same-cycle promotion is not.
            if (pend_vld_q && !promote && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // FSM next state, bit/byte timing, checksum accumulation and packet count.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        sum_d      = sum_q;
        pkt_cnt_d  = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (start_direct || promote) begin
                    state_d    = START;
                    clk_cnt_d  = 8'd0;
                    byte_cnt_d = 4'd0;
                    sum_d      = 8'd0;
                end
            end
            START: begin
                if (tick_done) begin
                    state_d   = DATA;
                    clk_cnt_d = 8'd0;
                    bit_cnt_d = 3'd0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (tick_done) begin
                    clk_cnt_d = 8'd0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            STOP: begin
                if (tick_done) begin
                    clk_cnt_d = 8'd0;
                    sum_d     = sum_q + cur_byte;
                    if (byte_cnt_q == LAST_BYTE) begin
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                        if (promote) begin
                            state_d    = START;
                            byte_cnt_d = 4'd0;
                            sum_d      = 8'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d    = START;
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level decoded from the registered state and counters.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_cnt_q];
            default: tx_d = 1'b1;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            clk_cnt_q     <= 8'd0;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= 4'd0;
            sum_q         <= 8'd0;
            act_pos_q     <= 24'd0;
            act_status_q  <= 8'd0;
            pend_pos_q    <= 24'd0;
            pend_status_q <= 8'd0;
            pend_vld_q    <= 1'b0;
            drop_cnt_q    <= 8'd0;
            pkt_cnt_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            clk_cnt_q     <= clk_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            sum_q         <= sum_d;
            act_pos_q     <= act_pos_d;
            act_status_q  <= act_status_d;
            pend_pos_q    <= pend_pos_d;
            pend_status_q <= pend_status_d;
            pend_vld_q    <= pend_vld_d;
            drop_cnt_q    <= drop_cnt_d;
            pkt_cnt_q     <= pkt_cnt_d;
        end
    end

    assign bus.tx        = tx_d;
    assign bus.busy      = (state_q != IDLE);
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.pkt_cnt   = pkt_cnt_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_biss_pos_uart_streamer.sv
// Directed bench for biss_pos_uart_streamer: default build (8 clk/bit) for
// packet content and flow control, plus a 2 clk/bit build for long runs.
module tb_biss_pos_uart_streamer;
    localparam int C0 = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   busy_cnt = 0;

    logic [7:0] rx_buf [0:8];
    int         rx_gap [0:8];
    bit         rx_ok;

    biss_pos_uart_streamer_if bus0 ();
    biss_pos_uart_streamer_if bus1 ();

    biss_pos_uart_streamer u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    biss_pos_uart_streamer #(.CLKS_PER_BIT(2), .CMD_CODE(148)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus0.busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus0.stream_en = 1'b0; bus0.scd_valid = 1'b0; bus0.scd_data = '0; bus0.crc_ok = 1'b0;
        bus1.stream_en = 1'b0; bus1.scd_valid = 1'b0; bus1.scd_data = '0; bus1.crc_ok = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic strobe0(input logic [31:0] d, input logic c);
        bus0.scd_data = d; bus0.crc_ok = c; bus0.scd_valid = 1'b1;
        @(negedge clk);
        bus0.scd_valid = 1'b0; bus0.scd_data = '0; bus0.crc_ok = 1'b0;
    endtask

    task automatic strobe1(input logic [31:0] d, input logic c);
        bus1.scd_data = d; bus1.crc_ok = c; bus1.scd_valid = 1'b1;
        @(negedge clk);
        bus1.scd_valid = 1'b0;
    endtask

    // Decode 9 UART bytes from bus0.tx, sampling mid-bit; returns at mid stop bit of byte 8.
    task automatic rx_packet(input int max_wait);
        rx_ok = 1'b1;
        for (int k = 0; k < 9; k++) begin
            int w;
            rx_buf[k] = 8'h00;
            w = 0;
            while (bus0.tx !== 1'b0 && w < max_wait) begin
                @(negedge clk);
                w++;
            end
            rx_gap[k] = w;
            if (bus0.tx !== 1'b0) begin
                rx_ok = 1'b0;
                return;
            end
            repeat (C0 / 2) @(negedge clk);
            if (bus0.tx !== 1'b0) rx_ok = 1'b0;
            for (int j = 0; j < 8; j++) begin
                repeat (C0) @(negedge clk);
                rx_buf[k][j] = bus0.tx;
            end
            repeat (C0) @(negedge clk);
            if (bus0.tx !== 1'b1) rx_ok = 1'b0;
        end
    endtask

    task automatic wait_idle0(input int limit);
        int n;
        n = 0;
        while (bus0.busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle1(input int limit);
        int n;
        n = 0;
        while (bus1.busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus0.tx !== 1'b1 || bus0.busy !== 1'b0) begin
            bad++; $display("FAIL reset_line: tx=%b busy=%b want tx=1 busy=0", bus0.tx, bus0.busy);
        end
        total++;
        if (bus0.drop_cnt !== 8'd0 || bus0.pkt_cnt !== 16'd0 || bus0.fsm_state !== 2'd0) begin
            bad++; $display("FAIL reset_cnt: drop=%0d pkt=%0d state=%0d want 0 0 0",
                            bus0.drop_cnt, bus0.pkt_cnt, bus0.fsm_state);
        end
        total++;
        if (bus1.tx !== 1'b1 || bus1.busy !== 1'b0 || bus1.drop_cnt !== 8'd0 || bus1.pkt_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_fast: tx=%b busy=%b drop=%0d pkt=%0d want 1 0 0 0",
                            bus1.tx, bus1.busy, bus1.drop_cnt, bus1.pkt_cnt);
        end
    endtask

    task automatic test_basic();
        logic [71:0] exp_pkt;
        int b0;
        exp_pkt = 72'h04_00_00_94_12_34_56_01_CB;
        do_reset();
        bus0.stream_en = 1'b1;
        b0 = busy_cnt;
        fork
            rx_packet(20);
            begin
                strobe0(32'h123456C0, 1'b1);
                total++;
                if (bus0.tx !== 1'b0 || bus0.busy !== 1'b1) begin
                    bad++; $display("FAIL basic_latency: tx=%b busy=%b want tx=0 busy=1", bus0.tx, bus0.busy);
                end
            end
        join
        total++;
        if (rx_ok !== 1'b1) begin bad++; $display("FAIL basic_frame: rx_ok=%b want 1", rx_ok); end
        for (int k = 0; k < 9; k++) begin
            total++;
            if (rx_buf[k] !== exp_pkt[71-8*k -: 8]) begin
                bad++; $display("FAIL basic_byte%0d: got %02h want %02h", k, rx_buf[k], exp_pkt[71-8*k -: 8]);
            end
        end
        repeat (10) @(negedge clk);
        total++;
        if (busy_cnt - b0 != 720) begin
            bad++; $display("FAIL basic_busy_len: got %0d want 720", busy_cnt - b0);
        end
        total++;
        if (bus0.pkt_cnt !== 16'd1 || bus0.tx !== 1'b1 || bus0.busy !== 1'b0) begin
            bad++; $display("FAIL basic_done: pkt=%0d tx=%b busy=%b want 1 1 0", bus0.pkt_cnt, bus0.tx, bus0.busy);
        end
    endtask

    task automatic test_checksum();
        logic [71:0] exp_pkt;
        logic [7:0]  s;
        exp_pkt = 72'h04_00_00_94_FF_FF_FF_06_65;
        do_reset();
        bus0.stream_en = 1'b1;
        fork
            rx_packet(20);
            strobe0(32'hFFFFFF00, 1'b0);
        join
        total++;
        if (rx_ok !== 1'b1) begin bad++; $display("FAIL chk_frame: rx_ok=%b want 1", rx_ok); end
        s = 8'h00;
        for (int k = 0; k < 9; k++) begin
            s = s + rx_buf[k];
            total++;
            if (rx_buf[k] !== exp_pkt[71-8*k -: 8]) begin
                bad++; $display("FAIL chk_byte%0d: got %02h want %02h", k, rx_buf[k], exp_pkt[71-8*k -: 8]);
            end
        end
        total++;
        if (s !== 8'h00) begin bad++; $display("FAIL chk_sum: got %02h want 00", s); end
        wait_idle0(50);
    endtask

    task automatic test_back_to_back();
        logic [71:0] exp_a, exp_c;
        exp_a = 72'h04_00_00_94_12_34_56_01_CB;
        exp_c = 72'h04_00_00_94_AB_CD_EF_05_FC;
        do_reset();
        bus0.stream_en = 1'b1;
        fork
            rx_packet(20);
            begin
                strobe0(32'h123456C0, 1'b1);
                repeat (3) @(negedge clk);
                strobe0(32'h11111100, 1'b1);
                repeat (50) @(negedge clk);
                strobe0(32'hABCDEF80, 1'b1);
            end
        join
        total++;
        if (rx_ok !== 1'b1) begin bad++; $display("FAIL b2b_frame_a: rx_ok=%b want 1", rx_ok); end
        for (int k = 0; k < 9; k++) begin
            total++;
            if (rx_buf[k] !== exp_a[71-8*k -: 8]) begin
                bad++; $display("FAIL b2b_a_byte%0d: got %02h want %02h", k, rx_buf[k], exp_a[71-8*k -: 8]);
            end
        end
        rx_packet(20);
        total++;
        if (rx_ok !== 1'b1 || rx_gap[0] != C0 / 2) begin
            bad++; $display("FAIL b2b_gap: rx_ok=%b gap=%0d want 1 %0d", rx_ok, rx_gap[0], C0 / 2);
        end
        for (int k = 0; k < 9; k++) begin
            total++;
            if (rx_buf[k] !== exp_c[71-8*k -: 8]) begin
                bad++; $display("FAIL b2b_c_byte%0d: got %02h want %02h", k, rx_buf[k], exp_c[71-8*k -: 8]);
            end
        end
        repeat (10) @(negedge clk);
        total++;
        if (bus0.drop_cnt !== 8'd1 || bus0.pkt_cnt !== 16'd2 || bus0.busy !== 1'b0) begin
            bad++; $display("FAIL b2b_counts: drop=%0d pkt=%0d busy=%b want 1 2 0",
                            bus0.drop_cnt, bus0.pkt_cnt, bus0.busy);
        end
    endtask

    task automatic test_stream_disable();
        logic [71:0] exp_a;
        bit quiet;
        exp_a = 72'h04_00_00_94_00_00_01_03_64;
        do_reset();
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe0(32'h12345600 + 32'(i), 1'b1);
            repeat (4) begin
                @(negedge clk);
                if (bus0.tx !== 1'b1 || bus0.busy !== 1'b0) quiet = 1'b0;
            end
        end
        total++;
        if (quiet !== 1'b1) begin bad++; $display("FAIL dis_ignore: quiet=%b want 1", quiet); end
        bus0.stream_en = 1'b1;
        fork
            rx_packet(20);
            begin
                strobe0(32'h00000140, 1'b1);
                repeat (5) @(negedge clk);
                strobe0(32'h55555500, 1'b1);
                repeat (10) @(negedge clk);
                bus0.stream_en = 1'b0;
            end
        join
        total++;
        if (rx_ok !== 1'b1) begin bad++; $display("FAIL dis_frame: rx_ok=%b want 1", rx_ok); end
        for (int k = 0; k < 9; k++) begin
            total++;
            if (rx_buf[k] !== exp_a[71-8*k -: 8]) begin
                bad++; $display("FAIL dis_byte%0d: got %02h want %02h", k, rx_buf[k], exp_a[71-8*k -: 8]);
            end
        end
        repeat (10) @(negedge clk);
        bus0.stream_en = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus0.tx !== 1'b1 || bus0.busy !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1) begin bad++; $display("FAIL dis_pending_discard: quiet=%b want 1", quiet); end
        total++;
        if (bus0.drop_cnt !== 8'd0 || bus0.pkt_cnt !== 16'd1) begin
            bad++; $display("FAIL dis_counts: drop=%0d pkt=%0d want 0 1", bus0.drop_cnt, bus0.pkt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [71:0] exp_pkt;
        bit quiet;
        exp_pkt = 72'h04_00_00_94_12_34_56_00_CC;
        do_reset();
        bus0.stream_en = 1'b1;
        strobe0(32'h0000FF00, 1'b1);
        wait_idle0(800);
        strobe0(32'h0ABCDEC0, 1'b1);
        repeat (10) @(negedge clk);
        strobe0(32'h01010100, 1'b1);
        repeat (10) @(negedge clk);
        strobe0(32'h02020200, 1'b1);
        repeat (400) @(negedge clk);
        total++;
        if (bus0.pkt_cnt !== 16'd1 || bus0.drop_cnt !== 8'd1 || bus0.busy !== 1'b1) begin
            bad++; $display("FAIL rmid_pre: pkt=%0d drop=%0d busy=%b want 1 1 1",
                            bus0.pkt_cnt, bus0.drop_cnt, bus0.busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (bus0.tx !== 1'b1 || bus0.busy !== 1'b0 || bus0.drop_cnt !== 8'd0 || bus0.pkt_cnt !== 16'd0) begin
            bad++; $display("FAIL rmid_abort: tx=%b busy=%b drop=%0d pkt=%0d want 1 0 0 0",
                            bus0.tx, bus0.busy, bus0.drop_cnt, bus0.pkt_cnt);
        end
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus0.tx !== 1'b1 || bus0.busy !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1) begin bad++; $display("FAIL rmid_no_pending: quiet=%b want 1", quiet); end
        fork
            rx_packet(20);
            strobe0(32'h123456C0, 1'b0);
        join
        total++;
        if (rx_ok !== 1'b1) begin bad++; $display("FAIL rmid_frame: rx_ok=%b want 1", rx_ok); end
        for (int k = 0; k < 9; k++) begin
            total++;
            if (rx_buf[k] !== exp_pkt[71-8*k -: 8]) begin
                bad++; $display("FAIL rmid_byte%0d: got %02h want %02h", k, rx_buf[k], exp_pkt[71-8*k -: 8]);
            end
        end
        wait_idle0(50);
        total++;
        if (bus0.pkt_cnt !== 16'd1) begin
            bad++; $display("FAIL rmid_pkt: got %0d want 1", bus0.pkt_cnt);
        end
    endtask

    task automatic test_fast_stream();
        do_reset();
        bus1.stream_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            strobe1(32'h00010000 * 32'(i) + 32'h000000C0, 1'b1);
            repeat (180) @(negedge clk);
        end
        wait_idle1(400);
        total++;
        if (bus1.busy !== 1'b0 || bus1.pkt_cnt !== 16'd300 || bus1.drop_cnt !== 8'd0) begin
            bad++; $display("FAIL fast_paced: busy=%b pkt=%0d drop=%0d want 0 300 0",
                            bus1.busy, bus1.pkt_cnt, bus1.drop_cnt);
        end
        bus1.scd_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            bus1.scd_data = 32'(i) << 8;
            bus1.crc_ok = 1'b1;
            @(negedge clk);
        end
        bus1.scd_valid = 1'b0;
        wait_idle1(1000);
        total++;
        if (bus1.busy !== 1'b0 || bus1.drop_cnt !== 8'd255) begin
            bad++; $display("FAIL fast_saturate: busy=%b drop=%0d want 0 255", bus1.busy, bus1.drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_checksum();
        test_back_to_back();
        test_stream_disable();
        test_reset_mid();
        test_fast_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/biss_pos_uart_streamer.md
Name: biss_pos_uart_streamer

Overview:
Downstream consumer of the BiSS-C master's single-cycle data (SCD) capture. It takes each accepted 32-bit SCD word and serialises a framed position packet on a UART TX line, so the host can stream angles without issuing per-sample read commands. It uses the same packet convention as existing host replies: length byte, two zero bytes, command byte, payload, and a checksum byte that makes the whole packet sum to zero modulo 256. It keeps a one-deep pending buffer and counts frames it had to drop.

Parameters:
CLKS_PER_BIT, 8, clk cycles per UART bit (460800 baud at 3.6864 MHz); legal range 2..255.
CMD_CODE, 148, command byte placed in packet byte 3.

Ports:
clk  input  1  single clock domain for all logic.
rst_n  input  1  synchronous, active-low reset.
stream_en  input  1  1 = capture and transmit frames; 0 = accept no new frames.
scd_valid  input  1  one-cycle strobe marking a new SCD word; already synchronous to clk.
scd_data  input  32  [31:8] position, [7] nError (active low), [6] nWarning (active low), [5:0] CRC field (ignored).
crc_ok  input  1  CRC6 result for scd_data, qualified by scd_valid.
tx  output  1  UART TX line, 8N1, LSB first, idle high.
busy  output  1  1 from packet start until the cycle after the last stop bit.
drop_cnt  output  8  number of frames overwritten in the pending buffer; saturates at 255.
pkt_cnt  output  16  number of packets fully sent; wraps.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge): tx=1, busy=0, drop_cnt=0, pkt_cnt=0. The FSM goes to IDLE and the pending flag clears. Reset mid-packet aborts transmission; tx is 1 after that edge.
- Packet, 9 bytes in this order: 0x04, 0x00, 0x00, CMD_CODE, pos[23:16], pos[15:8], pos[7:0], status, chk.
  - status = {5'b0, ~scd_data[6], ~scd_data[7], crc_ok}.
  - chk = (0 - (sum of bytes 0..7)) mod 256, computed with an 8-bit running accumulator.
- Capture: all payload fields are latched into the active register when a packet starts. Later input changes do not affect a packet in flight.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when scd_valid & stream_en, load the active register. Enter START on the next edge, which drives tx=0 and sets busy=1 (one-cycle latency from the strobe).
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If bytes remain, go to START for the next byte with no inter-byte gap.
    - After byte 8, increment pkt_cnt.
    - If the pending flag is set and stream_en=1, move pending into active, clear the flag, and go directly to START (back-to-back packets).
    - Otherwise go to IDLE with busy=0.
- Packet length is 90 bits, i.e. 90*CLKS_PER_BIT cycles (720 at default).
- Pending buffer: scd_valid & stream_en while busy stores the word into pending and sets the flag.
  - If the flag was already set, the older pending word is replaced (newest wins) and drop_cnt increments (saturating).
  - scd_valid on the same cycle the pending word is promoted to active: the new word goes into pending, and drop_cnt does not increment.
- stream_en=0: scd_valid is ignored and the pending flag clears without counting a drop. A packet already in flight completes unchanged.
- crc_ok=0 frames are still transmitted; they are flagged only by status[0]=0.
- Bit and byte counters are sized for CLKS_PER_BIT ≤ 255 and 9 bytes. No arithmetic overflow is permitted except the checksum (mod 256) and pkt_cnt (wraps).

Test Plan:
1. Reset, then stream_en=1 and one scd_valid with scd_data=0x123456C0, crc_ok=1 → tx falls one cycle later; decoded bytes 04 00 00 94 12 34 56 01 CB; busy high for 720 cycles; pkt_cnt=1.
2. scd_data=0xFFFFFF00, crc_ok=0 → status byte 0x06; checksum makes the 9-byte sum 0x00 mod 256; payload FF FF FF.
3. Three strobes during one packet (A active; B, then C while busy) → A sent, then C back-to-back with no idle bit; B never appears; drop_cnt=1; pkt_cnt=2.
4. stream_en=0 with scd_valid pulses → tx stays 1, busy=0; then drop stream_en mid-packet with pending set → current packet completes, pending discarded, drop_cnt unchanged.
5. Assert rst_n=0 during byte 5 → tx=1 and busy=0 after that edge; counters 0; the next strobe yields a complete, correct packet.
6. CLKS_PER_BIT=2 build: run 300 consecutive strobes one per packet period → drop_cnt=0, pkt_cnt=300; then 600 strobes one per cycle → drop_cnt saturates at 255.
